// File: rtl/spi_tx_frame_sched_if.sv
// spi_tx_frame_sched_if
//   Bus bundle between two framed byte requesters (A, B), the SPI byte
//   serializer and the frame scheduler.
//   Requester side : req_{a,b}_start/len/moment/data/valid in,
//                    req_{a,b}_grant/ready out
//   Serializer side: phy_send_flag, phy_empty in,
//                    phy_idle, phy_send_data/valid, phy_send_momment out
//   Status         : busy, frame_owner, frame_done, frame_err out
//   Modport master = requesters + serializer, slave = scheduler.
interface spi_tx_frame_sched_if #(
    parameter int LEN_W = 8
);
    logic             req_a_start;
    logic [LEN_W-1:0] req_a_len;
    logic [23:0]      req_a_moment;
    logic             req_a_grant;
    logic [7:0]       req_a_data;
    logic             req_a_valid;
    logic             req_a_ready;

    logic             req_b_start;
    logic [LEN_W-1:0] req_b_len;
    logic [23:0]      req_b_moment;
    logic             req_b_grant;
    logic [7:0]       req_b_data;
    logic             req_b_valid;
    logic             req_b_ready;

    logic             phy_idle;
    logic             phy_send_flag;
    logic             phy_empty;
    logic [7:0]       phy_send_data;
    logic             phy_send_valid;
    logic [23:0]      phy_send_momment;

    logic             busy;
    logic             frame_owner;
    logic             frame_done;
    logic             frame_err;

    modport master (
        output req_a_start, req_a_len, req_a_moment, req_a_data, req_a_valid,
        output req_b_start, req_b_len, req_b_moment, req_b_data, req_b_valid,
        output phy_send_flag, phy_empty,
        input  req_a_grant, req_a_ready, req_b_grant, req_b_ready,
        input  phy_idle, phy_send_data, phy_send_valid, phy_send_momment,
        input  busy, frame_owner, frame_done, frame_err
    );

    modport slave (
        input  req_a_start, req_a_len, req_a_moment, req_a_data, req_a_valid,
        input  req_b_start, req_b_len, req_b_moment, req_b_data, req_b_valid,
        input  phy_send_flag, phy_empty,
        output req_a_grant, req_a_ready, req_b_grant, req_b_ready,
        output phy_idle, phy_send_data, phy_send_valid, phy_send_momment,
        output busy, frame_owner, frame_done, frame_err
    );
endinterface

// File: rtl/spi_tx_frame_sched.sv
// spi_tx_frame_sched
//   Frame scheduler and round-robin arbiter for two byte requesters in front
//   of the SPI byte serializer. Latches one pending request per requester,
//   grants a frame, drops phy_idle, feeds one byte per phy_empty window,
//   drains the last byte for TAIL_CYC cycles and holds a GAP_CYC idle gap.
//   Ports: clock, rst (synchronous, active-high), bus (slave modport of
//   spi_tx_frame_sched_if carrying requester, serializer and status signals).
//   Optional: define SPI_TX_SCHED_TIMEOUT_EN to enable a stall watchdog in
//   WAIT_FLAG/XFER that aborts the frame with frame_err after TIMEOUT_CYC.
module spi_tx_frame_sched #(
    parameter int LEN_W       = 8,
    parameter int TAIL_CYC    = 16,
    parameter int GAP_CYC     = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input logic                 clock,
    input logic                 rst,
    spi_tx_frame_sched_if.slave bus
);
    localparam int TMR_W = $clog2(TAIL_CYC + GAP_CYC + TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ARB, S_WAIT_FLAG, S_XFER, S_DRAIN, S_GAP
    } state_t;

    state_t           state;
    logic             pend_a, pend_b;
    logic [LEN_W-1:0] len_a, len_b;
    logic [23:0]      mom_a, mom_b;
    logic             rr;            // 0: A wins a tie, 1: B wins
    logic [LEN_W-1:0] cnt;
    logic [TMR_W-1:0] tmr;
    logic             drain_armed;

    logic             grant_a_q, grant_b_q, idle_q, busy_q, owner_q;
    logic             send_valid_q, done_q;
    logic [7:0]       send_data_q;
    logic [23:0]      mom_q;

    logic grant_now, pick_b, clr_a, clr_b;
    logic stall_hit, ready_base, hs_a, hs_b;

    // The arbitration decision is taken in IDLE so the grant pulse is
    // visible during the ARB cycle itself.
    assign grant_now = (state == S_IDLE) && (pend_a || pend_b);
    assign pick_b    = pend_b && (!pend_a || rr);
    assign clr_a     = grant_now && !pick_b;
    assign clr_b     = grant_now && pick_b;

`ifdef SPI_TX_SCHED_TIMEOUT_EN
    logic err_q;
    assign stall_hit = ((state == S_WAIT_FLAG) || (state == S_XFER)) &&
                       (tmr == TMR_W'(TIMEOUT_CYC - 1));
    assign bus.frame_err = err_q;
`else
    assign stall_hit     = 1'b0;
    assign bus.frame_err = 1'b0;
`endif

    // Ready is withheld while a byte is being presented so that only one
    // byte goes out per phy_empty window.
    assign ready_base = (state == S_XFER) && bus.phy_empty && !send_valid_q &&
                        (cnt != '0) && !stall_hit;
    assign bus.req_a_ready = ready_base && !owner_q;
    assign bus.req_b_ready = ready_base && owner_q;
    assign hs_a = bus.req_a_valid && bus.req_a_ready;
    assign hs_b = bus.req_b_valid && bus.req_b_ready;

    assign bus.req_a_grant      = grant_a_q;
    assign bus.req_b_grant      = grant_b_q;
    assign bus.phy_idle         = idle_q;
    assign bus.phy_send_data    = send_data_q;
    assign bus.phy_send_valid   = send_valid_q;
    assign bus.phy_send_momment = mom_q;
    assign bus.busy             = busy_q;
    assign bus.frame_owner      = owner_q;
    assign bus.frame_done       = done_q;

    // Pending latches: a start landing on the grant cycle is re-latched.
    always_ff @(posedge clock) begin
        if (rst) begin
            pend_a <= 1'b0;
            pend_b <= 1'b0;
            len_a  <= '0;
            len_b  <= '0;
            mom_a  <= '0;
            mom_b  <= '0;
        end else begin
            if (clr_a) pend_a <= 1'b0;
            if (clr_b) pend_b <= 1'b0;
            if (bus.req_a_start && (bus.req_a_len != '0) && (!pend_a || clr_a)) begin
                pend_a <= 1'b1;
                len_a  <= bus.req_a_len;
                mom_a  <= bus.req_a_moment;
            end
            if (bus.req_b_start && (bus.req_b_len != '0) && (!pend_b || clr_b)) begin
                pend_b <= 1'b1;
                len_b  <= bus.req_b_len;
                mom_b  <= bus.req_b_moment;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state        <= S_IDLE;
            rr           <= 1'b0;
            cnt          <= '0;
            tmr          <= '0;
            drain_armed  <= 1'b0;
            grant_a_q    <= 1'b0;
            grant_b_q    <= 1'b0;
            idle_q       <= 1'b1;
            busy_q       <= 1'b0;
            owner_q      <= 1'b0;
            send_valid_q <= 1'b0;
            send_data_q  <= '0;
            mom_q        <= '0;
            done_q       <= 1'b0;
`ifdef SPI_TX_SCHED_TIMEOUT_EN
            err_q        <= 1'b0;
`endif
        end else begin
            grant_a_q    <= 1'b0;
            grant_b_q    <= 1'b0;
            send_valid_q <= 1'b0;
            done_q       <= 1'b0;
`ifdef SPI_TX_SCHED_TIMEOUT_EN
            err_q        <= 1'b0;
            if (stall_hit) begin
                err_q  <= 1'b1;
                done_q <= 1'b1;
                idle_q <= 1'b1;
                tmr    <= '0;
                state  <= S_GAP;
            end else
`endif
            case (state)
                S_IDLE: begin
                    if (grant_now) begin
                        owner_q   <= pick_b;
                        rr        <= !pick_b;
                        grant_a_q <= !pick_b;
                        grant_b_q <= pick_b;
                        cnt       <= pick_b ? len_b : len_a;
                        mom_q     <= pick_b ? mom_b : mom_a;
                        busy_q    <= 1'b1;
                        state     <= S_ARB;
                    end
                end
                S_ARB: begin
                    idle_q <= 1'b0;
                    tmr    <= '0;
                    state  <= S_WAIT_FLAG;
                end
                S_WAIT_FLAG: begin
                    if (bus.phy_send_flag) begin
                        tmr   <= '0;
                        state <= S_XFER;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                S_XFER: begin
                    if (hs_a || hs_b) begin
                        send_data_q  <= hs_a ? bus.req_a_data : bus.req_b_data;
                        send_valid_q <= 1'b1;
                        cnt          <= cnt - LEN_W'(1);
                        tmr          <= '0;
                        if (cnt == LEN_W'(1)) begin
                            drain_armed <= 1'b0;
                            state       <= S_DRAIN;
                        end
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                S_DRAIN: begin
                    // Tail count starts once the serializer has taken the
                    // last byte and reports empty again.
                    if (!drain_armed) begin
                        if (bus.phy_empty && !send_valid_q) begin
                            drain_armed <= 1'b1;
                            tmr         <= '0;
                        end
                    end else if (tmr == TMR_W'(TAIL_CYC - 1)) begin
                        done_q <= 1'b1;
                        idle_q <= 1'b1;
                        tmr    <= '0;
                        state  <= S_GAP;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                S_GAP: begin
                    if (tmr == TMR_W'(GAP_CYC - 1)) begin
                        busy_q <= 1'b0;
                        mom_q  <= '0;
                        state  <= S_IDLE;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_tx_frame_sched.sv
module tb_spi_tx_frame_sched;
    localparam int LEN_W = 8;

    logic clock = 1'b0;
    logic rst   = 1'b1;
    always #5 clock = ~clock;

    spi_tx_frame_sched_if #(.LEN_W(LEN_W)) bus ();

    spi_tx_frame_sched #(
        .LEN_W(LEN_W), .TAIL_CYC(16), .GAP_CYC(4), .TIMEOUT_CYC(32)
    ) dut (
        .clock(clock),
        .rst(rst),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [32:0] exp_bytes[$];   // {owner, moment, data}
    logic [1:0]  exp_frames[$];  // {err, owner}
    logic [7:0]  src_a[$];
    logic [7:0]  src_b[$];
    int          bytes_seen   = 0;
    logic        stall_empty  = 1'b0;
    int          shift_cnt    = 0;
    int          idle_low_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_byte(input logic own, input logic [23:0] mom, input logic [7:0] d);
        exp_bytes.push_back({own, mom, d});
        if (own) src_b.push_back(d);
        else     src_a.push_back(d);
    endtask

    // Serializer model and requester byte drivers.
    initial begin
        bus.req_a_valid = 1'b0; bus.req_a_data = '0;
        bus.req_b_valid = 1'b0; bus.req_b_data = '0;
        bus.phy_empty = 1'b1;   bus.phy_send_flag = 1'b0;
        forever begin
            @(negedge clock);
            if (bus.phy_idle) idle_low_cnt = 0;
            else              idle_low_cnt++;
            bus.phy_send_flag = (idle_low_cnt >= 2);
            if (bus.phy_send_valid) shift_cnt = 3;
            else if (shift_cnt > 0) shift_cnt--;
            bus.phy_empty = (shift_cnt == 0) && !stall_empty;
            bus.req_a_valid = (src_a.size() > 0);
            bus.req_a_data  = (src_a.size() > 0) ? src_a[0] : 8'h00;
            bus.req_b_valid = (src_b.size() > 0);
            bus.req_b_data  = (src_b.size() > 0) ? src_b[0] : 8'h00;
            #4;
            if (bus.req_a_valid && bus.req_a_ready) void'(src_a.pop_front());
            if (bus.req_b_valid && bus.req_b_ready) void'(src_b.pop_front());
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a byte or ends a frame.
    initial begin
        logic [32:0] eb;
        logic [1:0]  ef;
        forever begin
            @(negedge clock);
            if (bus.phy_send_valid) begin
                bytes_seen++;
                if (exp_bytes.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_byte: got 0x%0h expected none", bus.phy_send_data);
                end else begin
                    eb = exp_bytes.pop_front();
                    check("byte", {bus.frame_owner, bus.phy_send_momment, bus.phy_send_data}, eb);
                end
            end
            if (bus.frame_done) begin
                if (exp_frames.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_frame_done: got owner %0d expected none", bus.frame_owner);
                end else begin
                    ef = exp_frames.pop_front();
                    check("frame_end", {bus.frame_err, bus.frame_owner}, ef);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start(input logic sa, input logic [7:0] la, input logic [23:0] ma,
                               input logic sb, input logic [7:0] lb, input logic [23:0] mb);
        bus.req_a_start = sa; bus.req_a_len = la; bus.req_a_moment = ma;
        bus.req_b_start = sb; bus.req_b_len = lb; bus.req_b_moment = mb;
        @(negedge clock);
        bus.req_a_start = 1'b0;
        bus.req_b_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (!bus.frame_done && k < 400) begin @(negedge clock); k++; end
        check(name, bus.frame_done, 1'b1);
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (bus.busy && k < 400) begin @(negedge clock); k++; end
        check(name, bus.busy, 1'b0);
    endtask

    task automatic wait_bytes(input int target, input string name);
        int k = 0;
        while (bytes_seen < target && k < 400) begin @(negedge clock); k++; end
        check(name, bytes_seen >= target, 1'b1);
    endtask

    function automatic logic [9:0] ctrl_vec();
        return {bus.phy_idle, bus.busy, bus.frame_owner, bus.frame_done, bus.frame_err,
                bus.req_a_grant, bus.req_b_grant, bus.req_a_ready, bus.req_b_ready,
                bus.phy_send_valid};
    endfunction

    initial begin
        int   k;
        logic bad;
        bus.req_a_start = 1'b0; bus.req_a_len = '0; bus.req_a_moment = '0;
        bus.req_b_start = 1'b0; bus.req_b_len = '0; bus.req_b_moment = '0;
        repeat (3) @(negedge clock);
        check("reset_ctrl", ctrl_vec(), 10'b10_0000_0000);
        check("reset_moment", bus.phy_send_momment, 24'h0);
        check("reset_data", bus.phy_send_data, 8'h0);
        rst = 1'b0;
        @(negedge clock);

        // Single A frame, len 3, moment 0x10
        push_byte(1'b0, 24'h10, 8'h11);
        push_byte(1'b0, 24'h10, 8'h22);
        push_byte(1'b0, 24'h10, 8'h33);
        exp_frames.push_back(2'b00);
        bus.req_a_start = 1'b1; bus.req_a_len = 8'd3; bus.req_a_moment = 24'h10;
        k = 0;
        do begin
            @(negedge clock);
            bus.req_a_start = 1'b0;
            k++;
        end while (!bus.req_a_grant && k < 20);
        check("grant_latency", k, 2);
        check("grant_moment", bus.phy_send_momment, 24'h10);
        @(negedge clock);
        check("idle_falls_after_grant", {bus.phy_idle, bus.busy}, 2'b01);
        wait_done("t1_done");
        repeat (3) @(negedge clock);
        check("gap_idle_busy", {bus.phy_idle, bus.busy}, 2'b11);
        @(negedge clock);
        check("idle_after_gap", {bus.phy_idle, bus.busy, bus.phy_send_momment}, {2'b10, 24'h0});

        // Simultaneous pair from reset: A first
        rst = 1'b1; @(negedge clock); rst = 1'b0; @(negedge clock);
        push_byte(1'b0, 24'h20, 8'hA1);
        push_byte(1'b1, 24'h30, 8'hB1);
        exp_frames.push_back(2'b00);
        exp_frames.push_back(2'b01);
        pulse_start(1'b1, 8'd1, 24'h20, 1'b1, 8'd1, 24'h30);
        wait_done("pair1_first_done");
        @(negedge clock);
        wait_done("pair1_second_done");
        wait_idle("pair1_idle");

        // Single A frame moves the round-robin pointer to B
        push_byte(1'b0, 24'h40, 8'hC1);
        exp_frames.push_back(2'b00);
        pulse_start(1'b1, 8'd1, 24'h40, 1'b0, 8'd0, 24'h0);
        wait_done("single_a_done");
        wait_idle("single_a_idle");

        // Second pair: B first
        push_byte(1'b1, 24'h31, 8'hB2);
        push_byte(1'b0, 24'h21, 8'hA2);
        exp_frames.push_back(2'b01);
        exp_frames.push_back(2'b00);
        pulse_start(1'b1, 8'd1, 24'h21, 1'b1, 8'd1, 24'h31);
        wait_done("pair2_first_done");
        @(negedge clock);
        wait_done("pair2_second_done");
        wait_idle("pair2_idle");

        // len=0 is ignored
        pulse_start(1'b1, 8'd0, 24'h55, 1'b0, 8'd0, 24'h0);
        bad = 1'b0;
        repeat (10) begin
            @(negedge clock);
            bad = bad | bus.busy | bus.req_a_grant;
        end
        check("len0_ignored", bad, 1'b0);

        // phy_empty held low for 50 cycles mid-frame
        push_byte(1'b0, 24'h50, 8'h51);
        push_byte(1'b0, 24'h50, 8'h52);
        push_byte(1'b0, 24'h50, 8'h53);
        push_byte(1'b0, 24'h50, 8'h54);
        exp_frames.push_back(2'b00);
        k = bytes_seen;
        pulse_start(1'b1, 8'd4, 24'h50, 1'b0, 8'd0, 24'h0);
        wait_bytes(k + 2, "stall_first_bytes");
        stall_empty = 1'b1;
        bad = 1'b0;
        repeat (50) begin
            @(negedge clock);
            bad = bad | bus.req_a_ready | bus.phy_send_valid;
        end
        check("stall_quiet", bad, 1'b0);
        stall_empty = 1'b0;
        wait_done("stall_done");
        wait_idle("stall_idle");

        // Reset during XFER with 2 bytes remaining
        push_byte(1'b0, 24'h60, 8'h61);
        push_byte(1'b0, 24'h60, 8'h62);
        src_a.push_back(8'h63);
        src_a.push_back(8'h64);
        k = bytes_seen;
        pulse_start(1'b1, 8'd4, 24'h60, 1'b0, 8'd0, 24'h0);
        wait_bytes(k + 2, "mid_reset_bytes");
        rst = 1'b1;
        @(negedge clock);
        check("mid_reset_ctrl", ctrl_vec(), 10'b10_0000_0000);
        check("mid_reset_moment", bus.phy_send_momment, 24'h0);
        rst = 1'b0;
        src_a.delete();
        repeat (40) @(negedge clock);
        check("mid_reset_stays_idle", {bus.phy_idle, bus.busy}, 2'b10);

        // Requester never presents data after grant
        pulse_start(1'b1, 8'd2, 24'h70, 1'b0, 8'd0, 24'h0);
        k = 0;
        while (!bus.req_a_ready && k < 50) begin @(negedge clock); k++; end
        check("stall_xfer_reached", bus.req_a_ready, 1'b1);
`ifdef SPI_TX_SCHED_TIMEOUT_EN
        exp_frames.push_back(2'b10);
        k = 0;
        while (!bus.frame_err && k < 100) begin @(negedge clock); k++; end
        check("timeout_latency", k, 32);
        wait_idle("timeout_idle");
`else
        repeat (100) @(negedge clock);
        check("stuck_in_xfer", {bus.busy, bus.req_a_ready, bus.frame_err}, 3'b110);
        rst = 1'b1; @(negedge clock); rst = 1'b0; @(negedge clock);
`endif

        check("scoreboard_drained", exp_bytes.size() + exp_frames.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
